// File: rtl/control_fsm_if.sv
// Fetch/execute control bundle between the sequencer, instruction memory,
// ALU and register file.
interface control_fsm_if;
  logic        instr_req;
  logic [7:0]  pc_out;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [2:0]  alu_ctrl;
  logic [1:0]  alu_status;
  logic [3:0]  rf_raddr_a;
  logic [3:0]  rf_raddr_b;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic        halted;
  logic        illegal_op;

  modport master (
    output instr_req, pc_out, alu_ctrl, rf_raddr_a, rf_raddr_b,
           rf_we, rf_waddr, halted, illegal_op,
    input  instr_valid, instr_data, alu_status
  );

  modport slave (
    input  instr_req, pc_out, alu_ctrl, rf_raddr_a, rf_raddr_b,
           rf_we, rf_waddr, halted, illegal_op,
    output instr_valid, instr_data, alu_status
  );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle fetch/decode/exec sequencer for a 16-bit, 8-bit-PC core.
// Branch flags are sampled in DECODE so the preceding ALU op is already visible.
module control_fsm #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic          clk,
  input  logic          reset_n,
  control_fsm_if.master bus
);
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MOV  = 4'h3;
  localparam logic [3:0] OP_CMP  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_JZ   = 4'h6;
  localparam logic [3:0] OP_JN   = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_IDLE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_MOV  = 3'b011;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        ill_q, ill_d;
  logic [2:0]  alu_ctrl;
  logic        rf_we;

  logic [3:0] opc;
  logic [7:0] target;
  logic       st_zero, st_neg;

  assign opc     = ir_q[15:12];
  assign target  = ir_q[7:0];
  assign st_zero = bus.alu_status[1];
  assign st_neg  = bus.alu_status[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    ill_d    = ill_q;
    alu_ctrl = ALU_IDLE;
    rf_we    = 1'b0;
    case (state_q)
      FETCH: begin
        if (bus.instr_valid) begin
          ir_d    = bus.instr_data;
          pc_d    = pc_q + 8'd1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        case (opc)
          OP_NOP: state_d = FETCH;
          OP_ADD, OP_SUB, OP_MOV, OP_CMP: state_d = EXEC;
          OP_JMP: begin
            pc_d    = target;
            state_d = FETCH;
          end
          OP_JZ: begin
            if (st_zero) pc_d = target;
            state_d = FETCH;
          end
          OP_JN: begin
            if (st_neg) pc_d = target;
            state_d = FETCH;
          end
          OP_HALT: state_d = HALT;
          default: begin
            ill_d   = 1'b1;
            state_d = HALT;
          end
        endcase
      end
      EXEC: begin
        // CMP shares SUB's ALU op but only updates status, never the RF.
        case (opc)
          OP_ADD: begin alu_ctrl = ALU_ADD; rf_we = 1'b1; end
          OP_SUB: begin alu_ctrl = ALU_SUB; rf_we = 1'b1; end
          OP_MOV: begin alu_ctrl = ALU_MOV; rf_we = 1'b1; end
          OP_CMP: alu_ctrl = ALU_SUB;
          default: alu_ctrl = ALU_IDLE;
        endcase
        state_d = FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Reset leaves the FSM in FETCH, so the request is gated until release.
  assign bus.instr_req  = (state_q == FETCH) && reset_n;
  assign bus.pc_out     = pc_q;
  assign bus.alu_ctrl   = alu_ctrl;
  assign bus.rf_we      = rf_we;
  assign bus.rf_raddr_a = ir_q[11:8];
  assign bus.rf_raddr_b = ir_q[7:4];
  assign bus.rf_waddr   = ir_q[11:8];
  assign bus.halted     = (state_q == HALT);
  assign bus.illegal_op = ill_q;
endmodule
